// File: rtl/ptm_pkg.sv
// Shared PTM trace definitions: A-sync framing bytes and the stream
// controller state encoding. The decoder uses the same header constants.
package ptm_pkg;

    // A-sync is a run of PTM_ASYNC_BYTE closed by PTM_ASYNC_END
    localparam logic [7:0] PTM_ASYNC_BYTE = 8'h00;
    localparam logic [7:0] PTM_ASYNC_END  = 8'h80;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ptm_ctrl_state_e;

endpackage

// File: rtl/ptm_addr_fifo.sv
// Synchronous FIFO for decoded branch addresses. The head entry is held in
// a register, so oHead is valid in the same cycle oValid rises. iClr empties
// the FIFO in one cycle.
module ptm_addr_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             iClk,
    input  logic             iRsn,
    input  logic             iClr,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oHead,
    output logic             oValid,
    output logic [CNT_W-1:0] oCount
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] head;

    // Storage array; only slots between rd_ptr and wr_ptr are ever read, so no reset
    always_ff @(posedge iClk) begin
        if (iPush) begin
            mem[wr_ptr] <= iData;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (iClr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (iPush) wr_ptr <= wr_ptr + PTR_W'(1);
            if (iPop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({iPush, iPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head register: refilled from the next slot on pop, or straight from the
    // write data when the pushed entry becomes the head
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            head <= '0;
        end else if (iClr) begin
            head <= '0;
        end else if (iPop) begin
            if (count >= CNT_W'(2)) begin
                head <= mem[rd_ptr + PTR_W'(1)];
            end else if (iPush) begin
                head <= iData;
            end
        end else if (iPush && (count == '0)) begin
            head <= iData;
        end
    end

    assign oHead  = head;
    assign oValid = (count != '0);
    assign oCount = count;

    a_no_push_full: assert property (@(posedge iClk) disable iff (!iRsn)
        !(iPush && !iPop && !iClr && (count == CNT_W'(DEPTH))));
    a_no_pop_empty: assert property (@(posedge iClk) disable iff (!iRsn)
        !(iPop && !iClr && (count == '0)));

endmodule

// File: rtl/ptm_stream_ctrl.sv
// PTM stream controller: hunts for A-sync in the raw trace byte stream,
// keeps the decoder in reset until aligned, forwards bytes to it with
// back-pressure and buffers the decoded branch addresses for the sink.
module ptm_stream_ctrl
    import ptm_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int ASYNC_ZEROS = 5,
    parameter int LOST_W      = 16
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iValid,
    input  logic [7:0]        iData,
    output logic              oReady,
    input  logic              iResync,
    output logic              oDecRsn,
    output logic              oDecEn,
    output logic [7:0]        oDecData,
    input  logic [31:0]       iDecAddr,
    input  logic              iDecEn,
    output logic              oAddrValid,
    output logic [31:0]       oAddr,
    input  logic              iAddrReady,
    output logic              oSynced,
    output logic [LOST_W-1:0] oLostCnt
);

    localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int              ZC_W    = $clog2(ASYNC_ZEROS + 1);
    localparam logic [ZC_W-1:0] ZC_MAX  = ZC_W'(ASYNC_ZEROS);
    // Room for the entry pushed this cycle plus two bytes still in the decoder path
    localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(FIFO_DEPTH - 3);

    ptm_ctrl_state_e   state;
    logic [ZC_W-1:0]   zcnt;
    logic [LOST_W-1:0] lost_cnt;
    logic              alive;
    logic              dec_rsn_p1;
    logic              dec_en_p1;
    logic [7:0]        dec_data_p1;
    logic [CNT_W-1:0]  fifo_count;
    logic              fire;
    logic              fifo_clr;
    logic              fifo_push;
    logic              fifo_pop;

    function automatic logic [LOST_W-1:0] lost_sat_inc(input logic [LOST_W-1:0] v);
        return (&v) ? v : v + LOST_W'(1);
    endfunction

    function automatic logic [ZC_W-1:0] zcnt_sat_inc(input logic [ZC_W-1:0] v);
        return (v == ZC_MAX) ? v : v + ZC_W'(1);
    endfunction

    // Handshake: a resync request wins over a byte offered in the same cycle
    assign oReady = alive && (state != FLUSH) && (fifo_count <= RDY_MAX) && !iResync;
    assign fire   = iValid && oReady;

    // Alignment FSM, zero-run counter and lost-byte counter
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state    <= HUNT;
            zcnt     <= '0;
            lost_cnt <= '0;
            alive    <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (iResync || (state == FLUSH)) begin
                state <= iResync ? FLUSH : HUNT;
                zcnt  <= '0;
            end else if ((state == HUNT) && fire) begin
                lost_cnt <= lost_sat_inc(lost_cnt);
                if (iData == PTM_ASYNC_BYTE) begin
                    zcnt <= zcnt_sat_inc(zcnt);
                end else if ((iData == PTM_ASYNC_END) && (zcnt == ZC_MAX)) begin
                    state <= RUN;
                    zcnt  <= '0;
                end else begin
                    zcnt <= '0;
                end
            end
        end
    end

    // Decoder-facing registers: reset held until RUN, one strobe per accepted byte
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            dec_rsn_p1  <= 1'b0;
            dec_en_p1   <= 1'b0;
            dec_data_p1 <= '0;
        end else if (iResync || (state != RUN)) begin
            dec_rsn_p1 <= 1'b0;
            dec_en_p1  <= 1'b0;
        end else begin
            dec_rsn_p1 <= 1'b1;
            dec_en_p1  <= fire;
            if (fire) begin
                dec_data_p1 <= iData;
            end
        end
    end

    assign oDecRsn  = dec_rsn_p1;
    assign oDecEn   = dec_en_p1;
    assign oDecData = dec_data_p1;
    assign oSynced  = (state == RUN);
    assign oLostCnt = lost_cnt;

    // Decoder output only counts while aligned; anything arriving during a flush is stale
    assign fifo_clr  = iResync || (state == FLUSH);
    assign fifo_push = iDecEn && (state == RUN) && !fifo_clr;
    assign fifo_pop  = oAddrValid && iAddrReady && !fifo_clr;

    ptm_addr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_addr_fifo (
        .iClk   (iClk),
        .iRsn   (iRsn),
        .iClr   (fifo_clr),
        .iPush  (fifo_push),
        .iData  (iDecAddr),
        .iPop   (fifo_pop),
        .oHead  (oAddr),
        .oValid (oAddrValid),
        .oCount (fifo_count)
    );

endmodule

// File: tb/tb_ptm_stream_ctrl.sv
// Directed bench for ptm_stream_ctrl with a one-cycle behavioural decoder.
// Decoder address format: {16'hA5A5, sequence number, forwarded byte}.
module tb_ptm_stream_ctrl;

    localparam int LOST_W = 16;

    logic              iClk = 1'b0;
    logic              iRsn = 1'b0;
    logic              iValid = 1'b0;
    logic [7:0]        iData = 8'h00;
    logic              oReady;
    logic              iResync = 1'b0;
    logic              oDecRsn;
    logic              oDecEn;
    logic [7:0]        oDecData;
    logic [31:0]       iDecAddr = 32'h0;
    logic              iDecEn = 1'b0;
    logic              oAddrValid;
    logic [31:0]       oAddr;
    logic              iAddrReady = 1'b0;
    logic              oSynced;
    logic [LOST_W-1:0] oLostCnt;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mseq = 8'h00;
    int         dec_cnt = 0;
    logic [7:0] last_dec = 8'h00;

    ptm_stream_ctrl #(
        .FIFO_DEPTH  (8),
        .ASYNC_ZEROS (5),
        .LOST_W      (LOST_W)
    ) dut (
        .iClk       (iClk),
        .iRsn       (iRsn),
        .iValid     (iValid),
        .iData      (iData),
        .oReady     (oReady),
        .iResync    (iResync),
        .oDecRsn    (oDecRsn),
        .oDecEn     (oDecEn),
        .oDecData   (oDecData),
        .iDecAddr   (iDecAddr),
        .iDecEn     (iDecEn),
        .oAddrValid (oAddrValid),
        .oAddr      (oAddr),
        .iAddrReady (iAddrReady),
        .oSynced    (oSynced),
        .oLostCnt   (oLostCnt)
    );

    always #5 iClk = ~iClk;

    // Behavioural decoder: every strobed byte yields an address one cycle later
    always @(posedge iClk) begin
        iDecEn <= oDecEn;
        if (oDecEn) begin
            iDecAddr <= {16'hA5A5, mseq, oDecData};
            mseq     <= mseq + 8'd1;
        end
        if (oDecEn && oDecRsn) begin
            dec_cnt  <= dec_cnt + 1;
            last_dec <= oDecData;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Offer one byte and wait for it to be accepted; returns one step after the accepting edge
    task automatic send(input logic [7:0] b);
        int w;
        iValid = 1'b1;
        iData  = b;
        w = 0;
        #1;
        while (!oReady && (w < 50)) begin
            tick();
            w++;
        end
        if (!oReady) check("send_timeout", 32'(oReady), 32'd1);
        tick();
        iValid = 1'b0;
    endtask

    task automatic send_async(input int zeros);
        for (int i = 0; i < zeros; i++) send(8'h00);
        send(8'h80);
    endtask

    task automatic do_reset();
        iRsn = 1'b0;
        iValid = 1'b0;
        iResync = 1'b0;
        iAddrReady = 1'b0;
        tick();
        tick();
        iRsn = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  base;
        logic [7:0]  sent [$];
        int          nf;
        int          first_low;
        int          popk;
        int          dc;

        // ---- reset values
        tick();
        check("rst_ready",    32'(oReady),     32'd0);
        check("rst_decrsn",   32'(oDecRsn),    32'd0);
        check("rst_decen",    32'(oDecEn),     32'd0);
        check("rst_decdata",  32'(oDecData),   32'd0);
        check("rst_addrvld",  32'(oAddrValid), 32'd0);
        check("rst_addr",     oAddr,           32'd0);
        check("rst_synced",   32'(oSynced),    32'd0);
        check("rst_lost",     32'(oLostCnt),   32'd0);
        iRsn = 1'b1;
        tick();

        // ---- 1: 00x5,80,01
        for (int i = 0; i < 5; i++) send(8'h00);
        check("t1_synced_pre", 32'(oSynced), 32'd0);
        send(8'h80);
        check("t1_synced", 32'(oSynced), 32'd1);
        check("t1_lost",   32'(oLostCnt), 32'd6);
        check("t1_decrsn_entry", 32'(oDecRsn), 32'd0);
        send(8'h01);
        check("t1_decen",   32'(oDecEn),   32'd1);
        check("t1_decdata", 32'(oDecData), 32'h01);
        check("t1_decrsn",  32'(oDecRsn),  32'd1);
        tick();
        check("t1_decen_pulse", 32'(oDecEn), 32'd0);
        check("t1_vld_t2", 32'(oAddrValid), 32'd0);
        tick();
        check("t1_vld_t3", 32'(oAddrValid), 32'd1);
        check("t1_addr",   oAddr, 32'hA5A5_0001);
        check("t1_deccnt", 32'(dec_cnt), 32'd1);
        check("t1_lastdec", 32'(last_dec), 32'h01);
        iAddrReady = 1'b1;
        tick();
        iAddrReady = 1'b0;
        check("t1_vld_popped", 32'(oAddrValid), 32'd0);

        // ---- 2: short zero run, then long zero run
        do_reset();
        send_async(4);
        check("t2_short_synced", 32'(oSynced), 32'd0);
        check("t2_short_decrsn", 32'(oDecRsn), 32'd0);
        check("t2_short_lost",   32'(oLostCnt), 32'd5);
        send_async(6);
        check("t2_long_synced", 32'(oSynced), 32'd1);
        check("t2_long_lost",   32'(oLostCnt), 32'd12);
        tick();
        check("t2_decrsn", 32'(oDecRsn), 32'd1);

        // ---- 3: fill with sink stalled, then drain
        base = mseq;
        iAddrReady = 1'b0;
        iValid = 1'b1;
        iData = 8'h03;
        nf = 0;
        first_low = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (oReady) nf++;
            else if (first_low < 0) first_low = c;
            tick();
        end
        iValid = 1'b0;
        #1;
        check("t3_accepted", 32'(nf), 32'd8);
        check("t3_first_low", 32'(first_low), 32'd8);
        check("t3_ready_full", 32'(oReady), 32'd0);
        iAddrReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t3_drain_vld", 32'(oAddrValid), 32'd1);
            check("t3_drain_addr", oAddr, {16'hA5A5, 8'(base + 8'(k)), 8'h03});
            tick();
        end
        iAddrReady = 1'b0;
        check("t3_empty", 32'(oAddrValid), 32'd0);
        check("t3_ready_again", 32'(oReady), 32'd1);

        // ---- 4: resync with a byte offered in the same cycle
        send(8'h05);
        dc = dec_cnt;
        check("t4_decen_inflight", 32'(oDecEn), 32'd1);
        iResync = 1'b1;
        iValid  = 1'b1;
        iData   = 8'h07;
        #1;
        check("t4_ready_resync", 32'(oReady), 32'd0);
        tick();
        iResync = 1'b0;
        iValid  = 1'b0;
        check("t4_flush_synced", 32'(oSynced), 32'd0);
        check("t4_flush_decrsn", 32'(oDecRsn), 32'd0);
        check("t4_flush_decen",  32'(oDecEn),  32'd0);
        check("t4_flush_ready",  32'(oReady),  32'd0);
        tick();
        check("t4_hunt_vld",   32'(oAddrValid), 32'd0);
        check("t4_hunt_ready", 32'(oReady),     32'd1);
        check("t4_hunt_synced", 32'(oSynced),   32'd0);
        check("t4_deccnt", 32'(dec_cnt), 32'(dc + 1));
        check("t4_lost", 32'(oLostCnt), 32'd12);

        // ---- 5: steady push/pop at count 5
        send_async(5);
        check("t5_synced", 32'(oSynced), 32'd1);
        check("t5_lost", 32'(oLostCnt), 32'd18);
        base = mseq;
        for (int k = 0; k < 5; k++) begin
            send(8'h10 + 8'(k));
            sent.push_back(8'h10 + 8'(k));
        end
        tick();
        tick();
        tick();
        popk = 0;
        for (int i = 0; i < 22; i++) begin
            iValid = 1'b1;
            iData = 8'h20 + 8'(i);
            iAddrReady = (i >= 2);
            #1;
            check("t5_ready", 32'(oReady), 32'd1);
            if (iAddrReady) begin
                check("t5_vld", 32'(oAddrValid), 32'd1);
                check("t5_addr", oAddr, {16'hA5A5, 8'(base + 8'(popk)), sent[popk]});
                popk++;
            end
            sent.push_back(iData);
            @(posedge iClk);
            #1;
        end
        iValid = 1'b0;
        iAddrReady = 1'b1;
        while (popk < sent.size()) begin
            check("t5_tail_vld", 32'(oAddrValid), 32'd1);
            check("t5_tail_addr", oAddr, {16'hA5A5, 8'(base + 8'(popk)), sent[popk]});
            popk++;
            tick();
        end
        iAddrReady = 1'b0;
        check("t5_empty", 32'(oAddrValid), 32'd0);

        // ---- 6: asynchronous reset mid-packet, then re-sync
        send(8'h09);
        iValid = 1'b1;
        iData = 8'h0A;
        #2;
        iRsn = 1'b0;
        #1;
        check("t6_ready",   32'(oReady),     32'd0);
        check("t6_decrsn",  32'(oDecRsn),    32'd0);
        check("t6_decen",   32'(oDecEn),     32'd0);
        check("t6_decdata", 32'(oDecData),   32'd0);
        check("t6_vld",     32'(oAddrValid), 32'd0);
        check("t6_addr",    oAddr,           32'd0);
        check("t6_synced",  32'(oSynced),    32'd0);
        check("t6_lost",    32'(oLostCnt),   32'd0);
        iValid = 1'b0;
        tick();
        iRsn = 1'b1;
        tick();
        send_async(5);
        check("t6_resynced", 32'(oSynced), 32'd1);
        check("t6_relost",   32'(oLostCnt), 32'd6);
        send(8'h01);
        base = mseq;
        tick();
        tick();
        check("t6_addr_vld", 32'(oAddrValid), 32'd1);
        check("t6_addr_val", oAddr, {16'hA5A5, base, 8'h01});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
